// File: rtl/serial_memory_loader_pkg.sv
// Shared types and constants for the serial memory loader: FSM states,
// host opcodes, memory-port modes and a big-endian byte picker.
package serial_memory_loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned MODE_W  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_READ,
    ST_READWAIT,
    ST_SEND,
    ST_ACK
  } state_e;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] CMD_GO    = 8'h47;
  localparam logic [BYTE_W-1:0] CMD_HALT  = 8'h48;
  localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;

  localparam logic [MODE_W-1:0] WRITE_NONE = 3'd0;
  localparam logic [MODE_W-1:0] WRITE_WORD = 3'd3;
  localparam logic [MODE_W-1:0] READ_NONE  = 3'd0;
  localparam logic [MODE_W-1:0] READ_WORD  = 3'd3;

  // Byte idx of a word, MSB first (idx 0 = bits 31:24).
  function automatic logic [BYTE_W-1:0] be_byte(input logic [WORD_W-1:0] word,
                                                input logic [1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/serial_memory_loader_byte_shifter.sv
// 32-bit big-endian byte accumulator with a byte counter; shared by the
// address, count and data fields of a command.
module serial_memory_loader_byte_shifter
  import serial_memory_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_next_c,
  output logic [1:0]        byte_count
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  // Clear wins over shift so a completed field is consumed and discarded together.
  always_comb begin
    word_next_c = {word_q[WORD_W-BYTE_W-1:0], byte_in};
    word_d      = word_q;
    cnt_d       = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = word_next_c;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byte_count = cnt_q;

endmodule

// File: rtl/serial_memory_loader.sv
// Host command decoder that loads and reads processor memory over a byte
// stream, holding the processor paused until a run command arrives.
module serial_memory_loader
  import serial_memory_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxValid,
  input  logic [BYTE_W-1:0] rxByte,
  output logic              txValid,
  input  logic              txReady,
  output logic [BYTE_W-1:0] txByte,
  output logic              pause,
  output logic              externalMemoryControl,
  output logic [WORD_W-1:0] externalAddress,
  output logic [WORD_W-1:0] externalData,
  output logic [MODE_W-1:0] externalWriteMode,
  output logic [MODE_W-1:0] externalReadMode,
  input  logic [WORD_W-1:0] externalDataOut,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               is_write_q, is_write_d;
  logic               run_hold_q, run_hold_d;
  logic [WORD_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [COUNT_W-1:0] words_left_q, words_left_d;
  logic [WORD_W-1:0]  rd_buf_q, rd_buf_d;
  logic [1:0]         send_idx_q, send_idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               pause_q, pause_d;
  logic               busy_q, busy_d;
  logic [MODE_W-1:0]  wmode_q, wmode_d;
  logic [MODE_W-1:0]  rmode_q, rmode_d;
  logic               tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;

  logic               collecting_c;
  logic               tx_fire_c;
  logic               tmo_expired_c;
  logic               sh_clear_c;
  logic               sh_shift_c;
  logic [WORD_W-1:0]  sh_word_next_c;
  logic [1:0]         sh_count;

  assign collecting_c  = (state_q == ST_ADDR) || (state_q == ST_COUNT) || (state_q == ST_DATA);
  assign tx_fire_c     = tx_valid_q && txReady;
  assign tmo_expired_c = collecting_c && !rxValid && (tmo_q == TMO_LAST);
  assign sh_shift_c    = rxValid && collecting_c;
  // Any state change ends the current field, and IDLE keeps the shifter empty.
  assign sh_clear_c    = (state_q == ST_IDLE) || (state_d != state_q);

  serial_memory_loader_byte_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .clear       (sh_clear_c),
    .shift_en    (sh_shift_c),
    .byte_in     (rxByte),
    .word_next_c (sh_word_next_c),
    .byte_count  (sh_count)
  );

  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    run_hold_d   = run_hold_q;
    addr_d       = addr_q;
    data_d       = data_q;
    words_left_d = words_left_q;
    rd_buf_d     = rd_buf_q;
    send_idx_d   = send_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rxValid) begin
          case (rxByte)
            CMD_WRITE: begin
              is_write_d = 1'b1;
              state_d    = ST_ADDR;
            end
            CMD_READ: begin
              is_write_d = 1'b0;
              state_d    = ST_ADDR;
            end
            CMD_GO:   run_hold_d = 1'b0;
            CMD_HALT: run_hold_d = 1'b1;
            default:  ;
          endcase
        end
      end
      ST_ADDR: begin
        if (rxValid && sh_count == 2'd3) begin
          addr_d  = sh_word_next_c;
          state_d = is_write_q ? ST_COUNT : ST_READ;
        end
      end
      ST_COUNT: begin
        if (rxValid && sh_count == 2'd1) begin
          words_left_d = sh_word_next_c[COUNT_W-1:0];
          state_d      = (sh_word_next_c[COUNT_W-1:0] == '0) ? ST_ACK : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rxValid && sh_count == 2'd3) begin
          data_d  = sh_word_next_c;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d       = addr_q + 32'd4;
        words_left_d = words_left_q - 16'd1;
        state_d      = (words_left_q == 16'd1) ? ST_ACK : ST_DATA;
      end
      ST_READ: state_d = ST_READWAIT;
      ST_READWAIT: begin
        rd_buf_d   = externalDataOut;
        send_idx_d = 2'd0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_fire_c) begin
          if (send_idx_q == 2'd3) state_d = ST_IDLE;
          else                    send_idx_d = send_idx_q + 2'd1;
        end
      end
      ST_ACK: begin
        if (tx_fire_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled command is dropped; the partial word is never written.
    if (tmo_expired_c) state_d = ST_IDLE;

    tmo_d = (collecting_c && !rxValid && !tmo_expired_c) ? tmo_q + TMO_W'(1) : '0;

    pause_d    = run_hold_d || (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    wmode_d    = (state_d == ST_WRITE) ? WRITE_WORD : WRITE_NONE;
    rmode_d    = (state_d == ST_READ)  ? READ_WORD  : READ_NONE;
    tx_valid_d = (state_d == ST_SEND) || (state_d == ST_ACK);
    tx_byte_d  = tx_byte_q;
    if (state_d == ST_ACK)       tx_byte_d = ACK_BYTE;
    else if (state_d == ST_SEND) tx_byte_d = be_byte(rd_buf_d, send_idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      is_write_q   <= 1'b0;
      run_hold_q   <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      words_left_q <= '0;
      rd_buf_q     <= '0;
      send_idx_q   <= '0;
      tmo_q        <= '0;
      pause_q      <= 1'b1;
      busy_q       <= 1'b0;
      wmode_q      <= WRITE_NONE;
      rmode_q      <= READ_NONE;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= '0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      run_hold_q   <= run_hold_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      words_left_q <= words_left_d;
      rd_buf_q     <= rd_buf_d;
      send_idx_q   <= send_idx_d;
      tmo_q        <= tmo_d;
      pause_q      <= pause_d;
      busy_q       <= busy_d;
      wmode_q      <= wmode_d;
      rmode_q      <= rmode_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
    end
  end

  assign txValid               = tx_valid_q;
  assign txByte                = tx_byte_q;
  assign pause                 = pause_q;
  assign busy                  = busy_q;
  assign externalMemoryControl = busy_q;
  assign externalAddress       = addr_q;
  assign externalData          = data_q;
  assign externalWriteMode     = wmode_q;
  assign externalReadMode      = rmode_q;

endmodule

// File: tb/tb_serial_memory_loader.sv
// Randomized bench for serial_memory_loader: a host-level command model predicts
// memory writes and transmitted bytes, compared against monitored DUT activity.
module tb_serial_memory_loader;
  import serial_memory_loader_pkg::*;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic        txValid;
  logic        txReady = 1'b1;
  logic [7:0]  txByte;
  logic        pause;
  logic        externalMemoryControl;
  logic [31:0] externalAddress;
  logic [31:0] externalData;
  logic [2:0]  externalWriteMode;
  logic [2:0]  externalReadMode;
  logic [31:0] externalDataOut = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  serial_memory_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rxValid               (rxValid),
    .rxByte                (rxByte),
    .txValid               (txValid),
    .txReady               (txReady),
    .txByte                (txByte),
    .pause                 (pause),
    .externalMemoryControl (externalMemoryControl),
    .externalAddress       (externalAddress),
    .externalData          (externalData),
    .externalWriteMode     (externalWriteMode),
    .externalReadMode      (externalReadMode),
    .externalDataOut       (externalDataOut),
    .busy                  (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Processor memory: one-cycle read latency.
  logic [31:0] dev_mem [logic [31:0]];
  always @(posedge clk) begin
    if (externalWriteMode == WRITE_WORD) dev_mem[externalAddress] = externalData;
    if (externalReadMode == READ_WORD)
      externalDataOut <= dev_mem.exists(externalAddress) ? dev_mem[externalAddress] : 32'h0;
  end

  // Transmit sink: always ready, or 5 stalled cycles before each ready cycle.
  bit stall_en = 1'b0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!stall_en) begin
      txReady = 1'b1;
      stall_cnt = 0;
    end else if (txReady) begin
      txReady = 1'b0;
      stall_cnt = 0;
    end else if (stall_cnt == 4) begin
      txReady = 1'b1;
    end else begin
      stall_cnt++;
    end
  end

  // Output monitor, sampled mid-cycle.
  logic [7:0]  tx_log [$];
  logic [63:0] wr_log [$];
  int rd_pulses = 0, tx_glitch = 0, pause_glitch = 0, emc_glitch = 0;
  bit hold_prev = 1'b0;
  logic [7:0] hold_byte = 8'h0;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!txValid || txByte !== hold_byte)) tx_glitch++;
      hold_prev = txValid && !txReady;
      hold_byte = txByte;
      if (txValid && txReady) tx_log.push_back(txByte);
      if (externalWriteMode == WRITE_WORD) wr_log.push_back({externalAddress, externalData});
      if (externalReadMode == READ_WORD) rd_pulses++;
      if (busy && !pause) pause_glitch++;
      if (externalMemoryControl !== busy) emc_glitch++;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [logic [31:0]];
  logic [7:0]  exp_tx [$];
  logic [63:0] exp_wr [$];
  int exp_reads = 0;
  bit exp_hold = 1'b1;
  int tx_base = 0, wr_base = 0;

  function automatic int rg(input int m);
    return int'($urandom_range(0, m));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rxValid = 1'b1;
    rxByte  = b;
    tick(1);
    rxValid = 1'b0;
    rxByte  = 8'($urandom);
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax, input int last_gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], (i == 0) ? last_gap : rg(gmax));
  endtask

  task automatic cmd_write(input logic [31:0] addr, input logic [15:0] cnt, input int gmax);
    logic [31:0] a, d;
    send_byte(CMD_WRITE, rg(gmax));
    send_word(addr, gmax, rg(gmax));
    send_byte(cnt[15:8], rg(gmax));
    send_byte(cnt[7:0], rg(gmax));
    a = addr;
    for (int k = 0; k < int'(cnt); k++) begin
      d = $urandom;
      exp_wr.push_back({a, d});
      ref_mem[a] = d;
      send_word(d, gmax, (k == int'(cnt) - 1) ? 0 : 1 + rg(gmax));
      a = a + 32'd4;
    end
    exp_tx.push_back(ACK_BYTE);
  endtask

  task automatic cmd_read(input logic [31:0] addr, input int gmax);
    logic [31:0] w;
    send_byte(CMD_READ, rg(gmax));
    send_word(addr, gmax, 0);
    w = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
    exp_reads++;
  endtask

  task automatic finish_cmd(input string tag);
    int budget = 400;
    while (tx_log.size() < tx_base + exp_tx.size() && budget > 0) begin
      tick(1);
      budget--;
    end
    check_eq({tag, "_wait"}, 64'(budget > 0), 64'd1);
    tick(3);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_ntx"}, 64'(tx_log.size() - tx_base), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (tx_base + i < tx_log.size()) check_eq({tag, "_tx"}, 64'(tx_log[tx_base + i]), 64'(exp_tx[i]));
    check_eq({tag, "_nwr"}, 64'(wr_log.size() - wr_base), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (wr_base + i < wr_log.size()) check_eq({tag, "_wr"}, wr_log[wr_base + i], exp_wr[i]);
    check_eq({tag, "_pause"}, 64'(pause), 64'(exp_hold));
    check_eq({tag, "_reads"}, 64'(rd_pulses), 64'(exp_reads));
    tx_base = tx_log.size();
    wr_base = wr_log.size();
    exp_tx.delete();
    exp_wr.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pause"}, 64'(pause), 64'd1);
    check_eq({tag, "_emc"},   64'(externalMemoryControl), 64'd0);
    check_eq({tag, "_busy"},  64'(busy), 64'd0);
    check_eq({tag, "_txv"},   64'(txValid), 64'd0);
    check_eq({tag, "_txb"},   64'(txByte), 64'd0);
    check_eq({tag, "_wm"},    64'(externalWriteMode), 64'(WRITE_NONE));
    check_eq({tag, "_rm"},    64'(externalReadMode), 64'(READ_NONE));
    check_eq({tag, "_addr"},  64'(externalAddress), 64'd0);
    check_eq({tag, "_data"},  64'(externalData), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  op;
    int          sel;

    rst = 1'b1;
    rxValid = 1'b0;
    rxByte = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    check_reset_vals("reset");

    // Run: pause drops, memory port untouched, nothing sent.
    send_byte(CMD_GO, 0);
    exp_hold = 1'b0;
    finish_cmd("go");
    check_eq("go_emc", 64'(externalMemoryControl), 64'd0);

    // Two-word write with exact pulse timing and a byte dropped during WRITE.
    send_byte(CMD_WRITE, 1);
    send_word(32'h10, 0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hDEADBEEF, 0, 0);
    check_eq("w1_mode", 64'(externalWriteMode), 64'(WRITE_WORD));
    check_eq("w1_addr", 64'(externalAddress), 64'h10);
    check_eq("w1_data", 64'(externalData), 64'hDEADBEEF);
    check_eq("w1_pause", 64'(pause), 64'd1);
    send_byte(8'hAA, 0);
    send_word(32'h01234567, 2, 0);
    check_eq("w2_mode", 64'(externalWriteMode), 64'(WRITE_WORD));
    check_eq("w2_addr", 64'(externalAddress), 64'h14);
    check_eq("w2_data", 64'(externalData), 64'h01234567);
    tick(1);
    check_eq("ack_mode", 64'(externalWriteMode), 64'(WRITE_NONE));
    check_eq("ack_valid", 64'(txValid), 64'd1);
    check_eq("ack_byte", 64'(txByte), 64'(ACK_BYTE));
    exp_wr.push_back({32'h10, 32'hDEADBEEF});
    exp_wr.push_back({32'h14, 32'h01234567});
    ref_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h14] = 32'h01234567;
    exp_tx.push_back(ACK_BYTE);
    finish_cmd("w_dir");

    // Read back with a stalled transmitter.
    stall_en = 1'b1;
    cmd_read(32'h14, 1);
    finish_cmd("r_stall");
    stall_en = 1'b0;

    // Address wrap and empty write.
    cmd_write(32'hFFFFFFFC, 16'd2, 2);
    finish_cmd("w_wrap");
    cmd_read(32'h0, 0);
    finish_cmd("r_wrap0");
    cmd_write(32'h40, 16'd0, 1);
    finish_cmd("w_zero");

    // Partial word then silence: abort exactly after TMO idle cycles.
    send_byte(CMD_WRITE, 0);
    send_word(32'h100, 0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    tick(TMO - 1);
    check_eq("tmo_early", 64'(busy), 64'd1);
    tick(1);
    check_eq("tmo_abort", 64'(busy), 64'd0);
    finish_cmd("tmo");
    cmd_read(32'h100, 1);
    finish_cmd("r_after_tmo");

    // Unknown opcode is ignored.
    send_byte(8'h00, 0);
    check_eq("unk_busy", 64'(busy), 64'd0);
    finish_cmd("unk");

    // Randomized command mix.
    for (int n = 0; n < 40; n++) begin
      stall_en = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      sel = rg(19);
      if (sel < 8) begin
        cmd_write(a, 16'(rg(3)), 3);
      end else if (sel < 15) begin
        cmd_read(a, 3);
      end else if (sel < 17) begin
        send_byte(CMD_GO, 0);
        exp_hold = 1'b0;
      end else if (sel < 19) begin
        send_byte(CMD_HALT, 0);
        exp_hold = 1'b1;
      end else begin
        op = 8'($urandom);
        if (op == CMD_WRITE || op == CMD_READ || op == CMD_GO || op == CMD_HALT) op = 8'h00;
        send_byte(op, 0);
      end
      finish_cmd("rnd");
    end
    stall_en = 1'b0;

    // Reset mid-DATA: outputs return to reset values before the next edge.
    send_byte(CMD_GO, 0);
    exp_hold = 1'b0;
    finish_cmd("go2");
    send_byte(CMD_WRITE, 0);
    send_word(32'h20, 0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_hold = 1'b1;
    tick(1);
    finish_cmd("post_rst");
    cmd_read(32'h10, 2);
    finish_cmd("r_post_rst");

    check_eq("tx_stable", 64'(tx_glitch), 64'd0);
    check_eq("pause_busy", 64'(pause_glitch), 64'd0);
    check_eq("emc_busy", 64'(emc_glitch), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
